// File: rtl/octave_button_ctrl.sv
// octave_button_ctrl: turns the raw, bouncy octave-up/down buttons into
// single-cycle select commands (01 increase, 10 decrease, 00 hold).
// Each button is synchronized, then debounced. A small FSM emits one pulse
// per clean press and refuses to pulse while both buttons are involved.
// Optional feature macro: OCTAVE_AUTOREPEAT_EN re-issues the command while
// a button stays held (first repeat after REPEAT_DELAY, then every
// REPEAT_PERIOD cycles).
module octave_button_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 12500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [1:0] select
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // Reject configurations the debounce and repeat counters cannot express.
   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("octave_button_ctrl: invalid DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      UP_HELD = 2'd1,
      DN_HELD = 2'd2,
      LOCK    = 2'd3
   } state_t;

   logic [1:0] raw;     // bit 0 = up, bit 1 = down
   logic [1:0] level;   // debounced levels
   logic       up_d;
   logic       dn_d;

   assign raw  = {btn_down, btn_up};
   assign up_d = level[0];
   assign dn_d = level[1];

   // One synchronizer + debounce filter per button.
   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic            meta_reg;
      logic            sync_reg;
      logic            level_reg;
      logic [DB_W-1:0] cnt_reg;

      // Two-flop synchronizer, then flip the level only after DEBOUNCE_CYCLES
      // consecutive disagreeing samples; any agreement restarts the count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            meta_reg  <= 1'b0;
            sync_reg  <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
         end else begin
            meta_reg <= raw[gi];
            sync_reg <= meta_reg;
            if (sync_reg == level_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == DB_LAST) begin
               level_reg <= ~level_reg;
               cnt_reg   <= '0;
            end else begin
               cnt_reg <= cnt_reg + DB_W'(1);
            end
         end
      end

      assign level[gi] = level_reg;
   end

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] select_reg;
   logic [1:0] select_next;

   assign select = select_reg;

`ifdef OCTAVE_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt_reg;
   logic [REP_W-1:0] rep_cnt_next;
   logic             rep_first_reg;   // still waiting for the first (longer) repeat
   logic             rep_first_next;
   logic             rep_due;

   assign rep_due = rep_first_reg ? (rep_cnt_reg == REP_W'(REPEAT_DELAY - 1))
                                  : (rep_cnt_reg == REP_W'(REPEAT_PERIOD - 1));

   // Repeat timer: cycles since the last pulse issued while held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_reg   <= '0;
         rep_first_reg <= 1'b1;
      end else begin
         rep_cnt_reg   <= rep_cnt_next;
         rep_first_reg <= rep_first_next;
      end
   end
`endif

   // FSM state and registered command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         select_reg <= 2'b00;
      end else begin
         state_reg  <= state_next;
         select_reg <= select_next;
      end
   end

   // Next state and command; a release or a second button always wins over a repeat.
   always_comb begin
      state_next  = state_reg;
      select_next = 2'b00;
`ifdef OCTAVE_AUTOREPEAT_EN
      rep_cnt_next   = '0;
      rep_first_next = 1'b1;
`endif
      case (state_reg)
         IDLE: begin
            if (up_d && dn_d) begin
               state_next = LOCK;
            end else if (up_d) begin
               state_next  = UP_HELD;
               select_next = 2'b01;
            end else if (dn_d) begin
               state_next  = DN_HELD;
               select_next = 2'b10;
            end
         end
         UP_HELD: begin
            if (dn_d) begin
               state_next = LOCK;
            end else if (!up_d) begin
               state_next = IDLE;
            end else begin
`ifdef OCTAVE_AUTOREPEAT_EN
               if (rep_due) begin
                  select_next    = 2'b01;
                  rep_first_next = 1'b0;
               end else begin
                  rep_cnt_next   = rep_cnt_reg + REP_W'(1);
                  rep_first_next = rep_first_reg;
               end
`endif
            end
         end
         DN_HELD: begin
            if (up_d) begin
               state_next = LOCK;
            end else if (!dn_d) begin
               state_next = IDLE;
            end else begin
`ifdef OCTAVE_AUTOREPEAT_EN
               if (rep_due) begin
                  select_next    = 2'b10;
                  rep_first_next = 1'b0;
               end else begin
                  rep_cnt_next   = rep_cnt_reg + REP_W'(1);
                  rep_first_next = rep_first_reg;
               end
`endif
            end
         end
         LOCK: begin
            if (!up_d && !dn_d) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: doc/octave_button_ctrl.md
# octave_button_ctrl

Front-end controller for the octave register. Takes the raw, bouncy octave-up and octave-down push-buttons and produces the 2-bit `select` command consumed by the octave register: 01 = increase, 10 = decrease, 00 = hold. Each clean press yields exactly one single-cycle command. An optional auto-repeat mode re-issues the command while a button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles a synchronized input must differ from its debounced level before the level flips. Minimum 2.
- `REPEAT_DELAY`, default 50000000: cycles from the first pulse to the first repeat pulse (auto-repeat only).
- `REPEAT_PERIOD`, default 12500000: cycles between subsequent repeat pulses (auto-repeat only).
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `btn_up`  input  1  raw octave-up button, asynchronous, active-high.
- `btn_down`  input  1  raw octave-down button, asynchronous, active-high.
- `select`  output  2  registered command: 00 hold, 01 increase, 10 decrease. Never 11.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer, giving `up_s` and `dn_s`.
- **Debounce counters:** each input has its own counter, width `$clog2(DEBOUNCE_CYCLES)`.
  - The counter clears whenever the synchronized input equals its debounced level.
  - Otherwise the counter increments.
  - The debounced level (`up_d` or `dn_d`) toggles, and the counter clears, on the cycle the counter equals `DEBOUNCE_CYCLES-1` while the input still differs.
- **FSM states:** IDLE, UP_HELD, DN_HELD, LOCK. Transitions are evaluated on the debounced levels.
  - IDLE: `up_d`=1 and `dn_d`=0 → UP_HELD, pulse 01. `dn_d`=1 and `up_d`=0 → DN_HELD, pulse 10. Both high in the same cycle → LOCK, no pulse.
  - UP_HELD: `dn_d`=1 → LOCK, no pulse. Else `up_d`=0 → IDLE.
  - DN_HELD: mirror of UP_HELD.
  - LOCK: stays in LOCK until `up_d`=0 and `dn_d`=0, then → IDLE. No pulses are issued in LOCK. A release always returns through IDLE, so the remaining held button never produces a pulse.
- **Pulse width:** each pulse lasts exactly one cycle. `select` is 00 in every other cycle.
- **Limits:** no saturation is applied here. The octave register clamps the octave to the range 1..7.
- **Reset:** asserting `rst_n` low at any time, including mid-debounce or mid-repeat, immediately clears:
  - synchronizers, debounced levels and all counters to 0;
  - the FSM to IDLE;
  - `select` to 00.

  A button already held when reset releases produces one pulse after the normal debounce latency.

## Timing
- Reset value of `select`: 2'b00.
- **Press latency:** raw input first sampled high at edge 0 and held stable. Then:
  - the synchronizer output is high after edge 2;
  - the debounced level flips at edge `DEBOUNCE_CYCLES+2`;
  - `select` is registered at edge `DEBOUNCE_CYCLES+3` and lasts one cycle.
- **Release latency:** the debounced level falls `DEBOUNCE_CYCLES+2` edges after the raw release.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles is filtered completely. The counter restarts on every bounce.
- **Back-to-back presses:** the minimum spacing between two accepted presses of the same button is about `2*DEBOUNCE_CYCLES` cycles, covering the release and the re-press.

## Configuration
- Macro: `OCTAVE_AUTOREPEAT_EN`.
- **When defined:** a repeat counter runs in UP_HELD and DN_HELD. The counter clears on state entry.
  - The first repeat pulse issues `REPEAT_DELAY` cycles after the initial pulse.
  - Further pulses follow every `REPEAT_PERIOD` cycles while the button stays held.
  - Moving to LOCK or IDLE clears the counter and stops repeats.
- **When undefined:** the repeat logic is absent. `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored, and each press yields exactly one pulse.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- **Clean press:** `btn_up` held high for 30 cycles from edge 0 → `select`=01 for the single cycle at edge 7, 00 at all other times. Repeat the scenario for `btn_down` → 10 at edge 7.
- **Bounce:** `btn_up` toggles every 2 cycles for 20 cycles, then holds high → no pulse during bouncing; exactly one 01 pulse, 7 cycles after the input goes stable.
- **Simultaneous press:** both buttons rise in the same cycle and are held for 30 cycles → no pulse. Releasing `btn_down` alone → still no pulse. Releasing both, then pressing `btn_down` → one 10 pulse.
- **Second button while held:** `btn_up` held, `btn_down` pressed 20 cycles later → one 01 pulse only; the FSM enters LOCK; `select` never shows 11.
- **Reset mid-debounce:** `btn_up` rises, then `rst_n` is pulsed low 2 cycles later while `btn_up` stays high → `select`=00 during reset; one 01 pulse 7 edges after `rst_n` deasserts.
- **Auto-repeat (`OCTAVE_AUTOREPEAT_EN` defined):** `btn_up` held for 60 cycles → 01 pulses at edges 7, 27, 35, 43, 51, 59. With the macro undefined → a single 01 pulse at edge 7.
